// File: rtl/clock_pkg.sv
// Shared types and constants for the clock project's buzzer path.
package clock_pkg;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_KEY   = 2'd1,
        SRC_CHIME = 2'd2,
        SRC_ALARM = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEEP = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [19:0] TONE_ALARM = 20'd15000;
    localparam logic [19:0] TONE_CHIME = 20'd20000;
    localparam logic [19:0] TONE_KEY   = 20'd30000;
    localparam logic [4:0]  MAX_CHIME  = 5'd12;

    // Counter width that can hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [19:0] tone_of(input src_t s);
        case (s)
            SRC_ALARM: return TONE_ALARM;
            SRC_CHIME: return TONE_CHIME;
            SRC_KEY:   return TONE_KEY;
            default:   return 20'd0;
        endcase
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Divides clk down to a one-cycle millisecond tick; clr restarts the divider.
module ms_tick_gen
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV_W = cnt_width(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/chime_scheduler.sv
// Arbitrates the single tone generator between alarm, hourly chime and key click,
// and sequences the beep/gap pattern of whichever source owns it.
//
// state | meaning
// IDLE  | buzzer free, silent, waiting for a request
// BEEP  | tone of the owning source is sounding
// GAP   | silence between beeps of a chime or alarm
module chime_scheduler
    import clock_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int ON_TICKS  = 500,
    parameter int OFF_TICKS = 1500,
    parameter int KEY_TICKS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alarm_req,
    input  logic        chime_req,
    input  logic [4:0]  chime_count,
    input  logic        key_req,
    output logic [19:0] sound,
    output logic        busy,
    output logic [1:0]  active_src
);

    localparam int MS_MAX = (ON_TICKS > OFF_TICKS)
                          ? ((ON_TICKS > KEY_TICKS) ? ON_TICKS : KEY_TICKS)
                          : ((OFF_TICKS > KEY_TICKS) ? OFF_TICKS : KEY_TICKS);
    localparam int MS_W = cnt_width(MS_MAX);
    localparam logic [MS_W-1:0] ON_LAST  = MS_W'(ON_TICKS - 1);
    localparam logic [MS_W-1:0] OFF_LAST = MS_W'(OFF_TICKS - 1);
    localparam logic [MS_W-1:0] KEY_LAST = MS_W'(KEY_TICKS - 1);

    state_t           state, next_state;
    src_t             src, next_src;
    logic [4:0]       beeps_left, next_beeps;
    logic [MS_W-1:0]  ms_cnt;
    logic [MS_W-1:0]  ms_last;
    logic             ms_tick;
    logic             expire;
    logic             clr;
    logic [19:0]      sound_d, sound_q;
    logic             busy_d, busy_q;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (ms_tick)
    );

    always_comb begin
        ms_last = ON_LAST;
        if (state == ST_GAP) begin
            ms_last = OFF_LAST;
        end else if (src == SRC_KEY) begin
            ms_last = KEY_LAST;
        end
    end

    assign expire = ms_tick && (ms_cnt == ms_last);

    // Timers restart whenever the phase or the owner changes, and stay parked in IDLE.
    assign clr = (next_state != state) || (next_src != src) || (next_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            src        <= SRC_NONE;
            beeps_left <= '0;
        end else begin
            state      <= next_state;
            src        <= next_src;
            beeps_left <= next_beeps;
        end
    end

    always_comb begin
        next_state = state;
        next_src   = src;
        next_beeps = beeps_left;
        case (state)
            ST_IDLE: begin
                if (alarm_req) begin
                    next_state = ST_BEEP;
                    next_src   = SRC_ALARM;
                end else if (chime_req && (chime_count != 5'd0)) begin
                    next_state = ST_BEEP;
                    next_src   = SRC_CHIME;
                    next_beeps = (chime_count > MAX_CHIME) ? MAX_CHIME : chime_count;
                end else if (key_req) begin
                    next_state = ST_BEEP;
                    next_src   = SRC_KEY;
                end
            end
            ST_BEEP, ST_GAP: begin
                if (src == SRC_ALARM && !alarm_req) begin
                    next_state = ST_IDLE;
                    next_src   = SRC_NONE;
                    next_beeps = '0;
                end else if (src != SRC_ALARM && alarm_req) begin
                    next_state = ST_BEEP;
                    next_src   = SRC_ALARM;
                    next_beeps = '0;
                end else if (expire) begin
                    if (state == ST_GAP) begin
                        next_state = ST_BEEP;
                    end else if (src == SRC_CHIME) begin
                        next_beeps = beeps_left - 5'd1;
                        if (beeps_left == 5'd1) begin
                            next_state = ST_IDLE;
                            next_src   = SRC_NONE;
                        end else begin
                            next_state = ST_GAP;
                        end
                    end else if (src == SRC_ALARM) begin
                        next_state = ST_GAP;
                    end else begin
                        next_state = ST_IDLE;
                        next_src   = SRC_NONE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_src   = SRC_NONE;
                next_beeps = '0;
            end
        endcase
    end

    // Outputs are derived from the upcoming state so they switch on the same edge.
    always_comb begin
        sound_d = 20'd0;
        busy_d  = (next_state != ST_IDLE);
        if (next_state == ST_BEEP) begin
            sound_d = tone_of(next_src);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_cnt  <= '0;
            sound_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            if (clr) begin
                ms_cnt <= '0;
            end else if (ms_tick) begin
                ms_cnt <= ms_cnt + 1'b1;
            end
            sound_q <= sound_d;
            busy_q  <= busy_d;
        end
    end

    assign sound      = sound_q;
    assign busy       = busy_q;
    assign active_src = src;

endmodule

// File: tb/tb_chime_scheduler.sv
// Directed bench for chime_scheduler with short timing parameters.
module tb_chime_scheduler;

    logic        clk;
    logic        rst;
    logic        alarm_req;
    logic        chime_req;
    logic [4:0]  chime_count;
    logic        key_req;
    logic [19:0] sound;
    logic        busy;
    logic [1:0]  active_src;

    int n_cmp = 0;
    int n_err = 0;

    chime_scheduler #(
        .TICK_DIV  (4),
        .ON_TICKS  (2),
        .OFF_TICKS (3),
        .KEY_TICKS (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alarm_req   (alarm_req),
        .chime_req   (chime_req),
        .chime_count (chime_count),
        .key_req     (key_req),
        .sound       (sound),
        .busy        (busy),
        .active_src  (active_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Checks cycles i0..i0+n-1 of a pattern: tone for the first on_c of every
    // period cycles while i < busy_len, silent and idle afterwards.
    task automatic run_pat(input string tag, input int tone, input int on_c, input int period,
                           input int busy_len, input int i0, input int n, input int src);
        for (int i = i0; i < i0 + n; i++) begin
            @(negedge clk);
            if (i < busy_len) begin
                check_val($sformatf("%s sound[%0d]", tag, i), int'(sound),
                          ((i % period) < on_c) ? tone : 0);
                check_val($sformatf("%s busy[%0d]", tag, i), int'(busy), 1);
                check_val($sformatf("%s src[%0d]", tag, i), int'(active_src), src);
            end else begin
                check_val($sformatf("%s sound[%0d]", tag, i), int'(sound), 0);
                check_val($sformatf("%s busy[%0d]", tag, i), int'(busy), 0);
                check_val($sformatf("%s src[%0d]", tag, i), int'(active_src), 0);
            end
        end
    endtask

    task automatic pulse_chime(input logic [4:0] cnt);
        chime_req   = 1'b1;
        chime_count = cnt;
        @(posedge clk);
        #1;
        chime_req   = 1'b0;
        chime_count = 5'd0;
    endtask

    task automatic pulse_key();
        key_req = 1'b1;
        @(posedge clk);
        #1;
        key_req = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        alarm_req   = 1'b0;
        chime_req   = 1'b0;
        chime_count = 5'd0;
        key_req     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset sound", int'(sound), 0);
        check_val("reset busy", int'(busy), 0);
        check_val("reset src", int'(active_src), 0);
        rst = 1'b0;
        @(negedge clk);

        // chime of 3 beeps: 8 on / 12 off, busy for 48 cycles
        pulse_chime(5'd3);
        run_pat("chime3", 20000, 8, 20, 48, 0, 52, 2);

        // count 0 ignored; count 20 clamps to 12 beeps
        pulse_chime(5'd0);
        run_pat("chime0", 0, 0, 20, 0, 0, 10, 0);
        pulse_chime(5'd20);
        run_pat("chime20", 20000, 8, 20, 228, 0, 235, 2);

        // key click with a second key_req dropped mid-click
        pulse_key();
        run_pat("key", 30000, 4, 20, 4, 0, 2, 1);
        pulse_key();
        run_pat("key", 30000, 4, 20, 4, 2, 8, 1);

        // alarm preempts a chime in its second gap, chime is not resumed
        pulse_chime(5'd5);
        run_pat("pre chime", 20000, 8, 20, 88, 0, 31, 2);
        alarm_req = 1'b1;
        run_pat("pre alarm", 15000, 8, 20, 1000, 0, 46, 3);
        alarm_req = 1'b0;
        run_pat("pre release", 0, 0, 20, 0, 0, 100, 0);

        // simultaneous requests in IDLE: alarm wins
        alarm_req   = 1'b1;
        chime_req   = 1'b1;
        chime_count = 5'd4;
        key_req     = 1'b1;
        @(posedge clk);
        #1;
        chime_req   = 1'b0;
        chime_count = 5'd0;
        key_req     = 1'b0;
        run_pat("simul alarm", 15000, 8, 20, 1000, 0, 25, 3);
        alarm_req = 1'b0;
        run_pat("simul release", 0, 0, 20, 0, 0, 10, 0);

        // reset mid-beep, then a fresh chime runs its full count
        pulse_chime(5'd3);
        run_pat("rst chime", 20000, 8, 20, 48, 0, 4, 2);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst sound", int'(sound), 0);
        check_val("midrst busy", int'(busy), 0);
        check_val("midrst src", int'(active_src), 0);
        rst = 1'b0;
        @(negedge clk);
        pulse_chime(5'd3);
        run_pat("post rst chime", 20000, 8, 20, 48, 0, 52, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
